// File: rtl/rr_burst_arb.sv
// Round-robin arbiter with burst-limited ownership: one owner at a time, released on
// last beat, burst cap or request withdrawal, with same-cycle re-arbitration on release.
module rr_burst_arb #(
    parameter int REQ_NUM     = 4,
    parameter int REQ_WIDTH   = 2,
    parameter int BURST_MAX   = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REQ_NUM-1:0]     req_i,
    input  logic                   beat_i,
    input  logic                   last_i,
    output logic [REQ_NUM-1:0]     grant_o,
    output logic [REQ_WIDTH-1:0]   grant_idx_o,
    output logic                   grant_vld_o,
    output logic [BURST_WIDTH-1:0] burst_cnt_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [BURST_WIDTH-1:0] CAP     = BURST_WIDTH'(BURST_MAX - 1);
    localparam logic [REQ_WIDTH-1:0]   IDX_TOP = REQ_WIDTH'(REQ_NUM - 1);

    state_t               state;
    logic [REQ_WIDTH-1:0] ptr;
    logic [REQ_WIDTH-1:0] rel_ptr;
    logic [REQ_WIDTH-1:0] search_ptr;
    logic [REQ_WIDTH-1:0] win_idx;
    logic [REQ_WIDTH-1:0] cand;
    logic                 win_found;
    logic                 release_grant;
    int                   j;

    function automatic logic [REQ_NUM-1:0] onehot(input logic [REQ_WIDTH-1:0] idx);
        logic [REQ_NUM-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // While busy, the search always starts just past the owner so that a release
    // re-arbitrates with the owner at lowest priority in the same cycle.
    always_comb begin
        rel_ptr    = (grant_idx_o == IDX_TOP) ? '0 : grant_idx_o + 1'b1;
        search_ptr = (state == BUSY) ? rel_ptr : ptr;
        win_found  = 1'b0;
        win_idx    = '0;
        j          = 0;
        cand       = '0;
        // Descending scan: the last hit written is the closest to search_ptr.
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            j    = (int'(search_ptr) + k) % REQ_NUM;
            cand = REQ_WIDTH'(j);
            if (req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        release_grant = (beat_i && (last_i || (burst_cnt_o == CAP)))
                      || (!beat_i && !req_i[grant_idx_o]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_o     <= '0;
            grant_idx_o <= '0;
            grant_vld_o <= 1'b0;
            burst_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt_o <= '0;
                    if (win_found) begin
                        state       <= BUSY;
                        grant_o     <= onehot(win_idx);
                        grant_idx_o <= win_idx;
                        grant_vld_o <= 1'b1;
                    end
                end
                BUSY: begin
                    if (release_grant) begin
                        ptr         <= rel_ptr;
                        burst_cnt_o <= '0;
                        if (win_found) begin
                            grant_o     <= onehot(win_idx);
                            grant_idx_o <= win_idx;
                        end else begin
                            state       <= IDLE;
                            grant_o     <= '0;
                            grant_vld_o <= 1'b0;
                        end
                    end else if (beat_i) begin
                        burst_cnt_o <= burst_cnt_o + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arb.sv
// Directed bench for rr_burst_arb: hand-computed grant sequences with default parameters.
module tb_rr_burst_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_i;
    logic       beat_i;
    logic       last_i;
    logic [3:0] grant_o;
    logic [1:0] grant_idx_o;
    logic       grant_vld_o;
    logic [3:0] burst_cnt_o;

    int checks = 0;
    int errors = 0;

    rr_burst_arb #(
        .REQ_NUM(4), .REQ_WIDTH(2), .BURST_MAX(8), .BURST_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .beat_i(beat_i), .last_i(last_i),
        .grant_o(grant_o), .grant_idx_o(grant_idx_o), .grant_vld_o(grant_vld_o),
        .burst_cnt_o(burst_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic vld, input logic [3:0] cnt);
        chk({tag, ".grant"}, 32'(grant_o), 32'(g));
        chk({tag, ".idx"},   32'(grant_idx_o), 32'(idx));
        chk({tag, ".vld"},   32'(grant_vld_o), 32'(vld));
        chk({tag, ".cnt"},   32'(burst_cnt_o), 32'(cnt));
    endtask

    initial begin
        rst = 1'b1; req_i = 4'b1010; beat_i = 1'b0; last_i = 1'b0;
        #1;
        step(); step();
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 4'd0);

        // First arbitration after reset
        rst = 1'b0;
        step();
        chk_all("first_grant", 4'b0010, 2'd1, 1'b1, 4'd0);

        // Burst cap with requester 3 pending
        beat_i = 1'b1;
        for (int b = 1; b <= 7; b++) begin
            step();
            chk($sformatf("cap_cnt%0d", b), 32'(burst_cnt_o), 32'(b));
            chk($sformatf("cap_hold%0d", b), 32'(grant_o), 32'b0010);
        end
        step();
        chk_all("cap_release", 4'b1000, 2'd3, 1'b1, 4'd0);

        // Wrap 3 -> 0, then 0 -> 3
        req_i = 4'b1001; last_i = 1'b1;
        step();
        chk_all("wrap_to0", 4'b0001, 2'd0, 1'b1, 4'd0);
        step();
        chk_all("wrap_to3", 4'b1000, 2'd3, 1'b1, 4'd0);

        // Owner 0 withdraws with requester 2 waiting
        req_i = 4'b0001;
        step();
        chk("own0", 32'(grant_o), 32'b0001);
        req_i = 4'b0100; beat_i = 1'b0; last_i = 1'b0;
        step();
        chk_all("withdraw_to2", 4'b0100, 2'd2, 1'b1, 4'd0);

        // Sole requester 2 re-granted after last on 3rd beat
        beat_i = 1'b1;
        step();
        chk("sole_cnt1", 32'(burst_cnt_o), 32'd1);
        step();
        chk("sole_cnt2", 32'(burst_cnt_o), 32'd2);
        last_i = 1'b1;
        step();
        chk_all("sole_regrant", 4'b0100, 2'd2, 1'b1, 4'd0);

        // last_i without beat_i is ignored
        beat_i = 1'b0;
        step();
        chk_all("last_no_beat", 4'b0100, 2'd2, 1'b1, 4'd0);

        // Withdraw with nobody waiting, then beats in IDLE are ignored
        req_i = 4'b0000; last_i = 1'b0;
        step();
        chk("idle_vld", 32'(grant_vld_o), 32'd0);
        chk("idle_grant", 32'(grant_o), 32'd0);
        beat_i = 1'b1; last_i = 1'b1;
        step();
        chk("idle_beat_vld", 32'(grant_vld_o), 32'd0);
        chk("idle_beat_cnt", 32'(burst_cnt_o), 32'd0);

        // Owner 0 withdraws with no other requester
        beat_i = 1'b0; last_i = 1'b0; req_i = 4'b0001;
        step();
        chk("own0b", 32'(grant_o), 32'b0001);
        req_i = 4'b0000;
        step();
        chk("withdraw_idle_vld", 32'(grant_vld_o), 32'd0);

        // Reset mid-burst (ptr is 1 here, so requester 1 wins first)
        req_i = 4'b1111;
        step();
        chk("pre_rst_grant", 32'(grant_o), 32'b0010);
        beat_i = 1'b1;
        for (int b = 0; b < 5; b++) step();
        chk("pre_rst_cnt", 32'(burst_cnt_o), 32'd5);
        rst = 1'b1;
        step();
        chk_all("mid_rst", 4'b0000, 2'd0, 1'b0, 4'd0);
        rst = 1'b0; beat_i = 1'b0;
        step();
        chk_all("post_rst", 4'b0001, 2'd0, 1'b1, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
